inst_rom_arbiter: RTL
=====================

// Module: inst_rom_arbiter
// PURPOSE
//  Shares the single combinational instruction ROM between the fetch stage (pc_reg/IF)
//  and the data side (loads from code space). Arbitrates per cycle and drives ROM ce/addr.
//  Registers ROM data into a per-port response with one-cycle latency.
//  Raises a fetch stall request to ctrl while fetch loses arbitration.
// PARAMETERS
//  ADDR_W      32  width of the requester and ROM address buses
//  DATA_W      32  width of the ROM word and response data
//  STARVE_MAX  3   consecutive mem wins under contention before fetch is forced through (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       reset, asynchronous, active-high
//  if_req       in   1       fetch request, level; held until granted
//  if_addr      in   ADDR_W  fetch byte address
//  if_gnt       out  1       fetch granted this cycle (combinational)
//  if_rvalid    out  1       fetch response valid (registered, 1-cycle pulse)
//  if_rdata     out  DATA_W  fetch response word (registered)
//  mem_req      in   1       data-side request, level; held until granted
//  mem_addr     in   ADDR_W  data-side byte address
//  mem_gnt      out  1       data-side granted this cycle (combinational)
//  mem_rvalid   out  1       data-side response valid (registered, 1-cycle pulse)
//  mem_rdata    out  DATA_W  data-side response word (registered)
//  flush        in   1       pipeline flush; blocks a new fetch grant this cycle
//  rom_ce       out  1       ROM chip enable, 1 = enabled
//  rom_addr     out  ADDR_W  ROM address (passed unmodified; ROM drops addr[1:0])
//  rom_inst     in   DATA_W  ROM read data, combinational from rom_ce/rom_addr
//  stallreq_if  out  1       fetch stall request to ctrl
// BEHAVIOUR
//  - Reset (rst=1, async): if_rvalid=mem_rvalid=0; if_rdata=mem_rdata=0; starve_cnt=0.
//    While rst=1: if_gnt=mem_gnt=0, rom_ce=0, rom_addr=0, stallreq_if=0.
//  - Eligibility: fetch is eligible when if_req & ~flush; mem is eligible when mem_req.
//  - Grant (combinational, at most one per cycle):
//    - Only one port eligible: grant that port.
//    - Both eligible: grant mem, unless starve_cnt==STARVE_MAX, in which case grant fetch.
//    - Neither eligible: no grant.
//  - starve_cnt (sequential, $clog2(STARVE_MAX+1) bits):
//    - Increments on edges where both ports are eligible and mem is granted; saturates.
//    - Clears on any edge where fetch is granted or if_req=0. Otherwise holds.
//  - ROM drive: rom_ce = if_gnt|mem_gnt; rom_addr = granted port's addr, else 0.
//  - Response: on the edge ending a granted cycle N, rom_inst is captured into the granted
//    port's rdata and that port's rvalid=1 during N+1 only. The other rdata holds.
//    No grant in N -> both rvalid=0 in N+1. Back-to-back grants give zero bubbles.
//  - stallreq_if = if_req & ~if_gnt & ~flush.
//    While flush=1, fetch is neither granted nor stalled; mem is unaffected.
//  - flush does not cancel if_rvalid already being presented. Only new grants are blocked.
//  - Misaligned addresses (addr[1:0]!=0) are forwarded unchanged; no error is raised.
//  - Async reset between a grant and its capture edge: no rvalid is produced for that grant.
// TESTING
//  1. Only if_req=1, if_addr=32'h4, rom_inst=32'h34011100 -> same cycle: if_gnt=1, rom_ce=1,
//     rom_addr=32'h4; next cycle: if_rvalid=1, if_rdata=32'h34011100, then if_rvalid=0.
//  2. if_req=mem_req=1 held, STARVE_MAX=3 -> grant sequence mem,mem,mem,if,mem,mem,mem,if;
//     stallreq_if=1 exactly on mem-grant cycles.
//  3. if_req=1, flush=1 for one cycle -> if_gnt=0, rom_ce=0, stallreq_if=0, no if_rvalid next;
//     the cycle after flush drops, fetch is granted normally.
//  4. Grant mem (mem_addr=32'h10), pulse rst mid-cycle before the edge -> mem_rvalid stays 0,
//     mem_rdata=0 immediately, starve_cnt=0, rom_ce=0 while rst high.
//  5. Requests alternate if/mem every cycle with distinct rom_inst values -> if_rvalid and
//     mem_rvalid alternate with no gaps; each rdata matches the word of its own grant cycle.
//  6. No requests for 5 cycles after traffic -> rom_ce=0, rom_addr=0, both rvalid=0,
//     both rdata hold their last captured words.

Source files
------------

// File: rtl/inst_rom_arbiter.sv
// Per-cycle arbiter sharing one combinational instruction ROM between fetch and the data side.
// Grants are combinational; ROM data is registered into a per-port response one cycle later.
module inst_rom_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    output logic              mem_gnt_o,
    output logic              mem_rvalid_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    input  logic              flush_i,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_inst_i,
    output logic              stallreq_if_o
);
    localparam int NUM_PORTS = 2;  // port 0 = fetch, port 1 = mem
    localparam int CNT_W     = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic                              if_elig, mem_elig, both_elig;
    logic                              if_gnt, mem_gnt;
    logic [CNT_W-1:0]                  starve_q, starve_d;
    logic [NUM_PORTS-1:0]              gnt;
    logic [NUM_PORTS-1:0]              rvalid_q;
    logic [NUM_PORTS-1:0][DATA_W-1:0]  rdata_q;

    assign if_elig   = if_req_i & ~flush_i;
    assign mem_elig  = mem_req_i;
    assign both_elig = if_elig & mem_elig;

    // Mem wins contention until fetch has lost STARVE_MAX times in a row.
    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (!rst) begin
            if (both_elig) begin
                if (starve_q == CNT_MAX) if_gnt  = 1'b1;
                else                     mem_gnt = 1'b1;
            end else begin
                if_gnt  = if_elig;
                mem_gnt = mem_elig;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (if_gnt || !if_req_i)
            starve_d = '0;
        else if (both_elig && mem_gnt && starve_q != CNT_MAX)
            starve_d = starve_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign gnt           = {mem_gnt, if_gnt};
    assign if_gnt_o      = if_gnt;
    assign mem_gnt_o     = mem_gnt;
    assign rom_ce_o      = if_gnt | mem_gnt;
    assign rom_addr_o    = if_gnt ? if_addr_i : (mem_gnt ? mem_addr_i : '0);
    assign stallreq_if_o = ~rst & if_req_i & ~if_gnt & ~flush_i;

    genvar p;
    generate
        for (p = 0; p < NUM_PORTS; p++) begin : g_rsp
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_q[p] <= 1'b0;
                    rdata_q[p]  <= '0;
                end else begin
                    rvalid_q[p] <= gnt[p];
                    if (gnt[p]) rdata_q[p] <= rom_inst_i;
                end
            end
        end
    endgenerate

    assign if_rvalid_o  = rvalid_q[0];
    assign if_rdata_o   = rdata_q[0];
    assign mem_rvalid_o = rvalid_q[1];
    assign mem_rdata_o  = rdata_q[1];
endmodule
